// File: rtl/mult_control.sv
// Control FSM for a radix-4 (modified Booth) sequential multiplier.
// Latency: start sampled at edge k -> WIDTH/2 RUN cycles (k+1..k+STEPS), ready from edge k+STEPS.
// No backpressure: strobes are Mealy decodes of data_in; start restarts the sequence at any time.
module mult_control #(
    parameter int WIDTH = 32
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       start,
    input  logic [2:0] data_in,
    output logic       add,
    output logic       sub,
    output logic       shiftMultiplicand,
    output logic       shiftProduct,
    output logic       nop,
    output logic       ready
);

    localparam int STEPS = WIDTH / 2;
    localparam int CW    = $clog2(STEPS) + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;

    // State and step counter registers; reset wins over everything.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state logic: start always restarts; RUN counts STEPS cycles then parks in DONE.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (start) begin
            state_d = RUN;
            cnt_d   = '0;
        end else begin
            case (state_q)
                IDLE: state_d = IDLE;
                RUN: begin
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == CW'(STEPS - 1)) begin
                        state_d = DONE;
                    end
                end
                DONE: state_d = DONE;
                default: begin
                    // Unused encoding: fall back to a clean idle.
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    // Mealy outputs: Booth window decode during RUN so the datapath acts this cycle.
    always_comb begin
        add               = 1'b0;
        sub               = 1'b0;
        shiftMultiplicand = 1'b0;
        shiftProduct      = 1'b0;
        nop               = 1'b0;
        ready             = 1'b0;
        case (state_q)
            RUN: begin
                shiftProduct = 1'b1;
                case (data_in)
                    3'b000: nop = 1'b1;
                    3'b001: add = 1'b1;
                    3'b010: add = 1'b1;
                    3'b011: begin
                        add               = 1'b1;
                        shiftMultiplicand = 1'b1;
                    end
                    3'b100: begin
                        sub               = 1'b1;
                        shiftMultiplicand = 1'b1;
                    end
                    3'b101: sub = 1'b1;
                    3'b110: sub = 1'b1;
                    default: nop = 1'b1;
                endcase
            end
            DONE:    ready = 1'b1;
            default: ready = 1'b0;
        endcase
    end

endmodule

// File: tb/tb_mult_control.sv
// Bench for mult_control: WIDTH=32 and WIDTH=8 instances share one stimulus stream.
// Latency: a reference model advances on each rising edge, outputs compared on falling edges.
// No backpressure in the design; stimulus is directed scenarios followed by random traffic.
module tb_mult_control;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b1;
    logic [2:0] data_in = 3'b000;

    logic add32, sub32, sm32, sp32, nop32, rdy32;
    logic add8,  sub8,  sm8,  sp8,  nop8,  rdy8;

    int n_checks = 0;
    int n_err    = 0;
    bit chk_en   = 1'b0;

    // Reference model state: RUN cycles still to come, and whether the product is complete.
    int left32 = 0, left8 = 0;
    bit done32 = 1'b0, done8 = 1'b0;

    always #5 clock = ~clock;

    mult_control #(.WIDTH(32)) dut32 (
        .clock(clock), .reset(reset), .start(start), .data_in(data_in),
        .add(add32), .sub(sub32), .shiftMultiplicand(sm32), .shiftProduct(sp32),
        .nop(nop32), .ready(rdy32)
    );

    mult_control #(.WIDTH(8)) dut8 (
        .clock(clock), .reset(reset), .start(start), .data_in(data_in),
        .add(add8), .sub(sub8), .shiftMultiplicand(sm8), .shiftProduct(sp8),
        .nop(nop8), .ready(rdy8)
    );

    wire [5:0] o32 = {add32, sub32, sm32, sp32, nop32, rdy32};
    wire [5:0] o8  = {add8,  sub8,  sm8,  sp8,  nop8,  rdy8};

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    // Expected {add,sub,shiftMult,shiftProd,nop,ready} from the Booth digit value -2*b2+b1+b0.
    function automatic logic [5:0] expect_out(input int left, input bit done, input logic [2:0] w);
        int v;
        logic [5:0] r;
        r = 6'b0;
        v = (w[1] ? 1 : 0) + (w[0] ? 1 : 0) - (w[2] ? 2 : 0);
        if (left > 0) begin
            r[5] = (v > 0);
            r[4] = (v < 0);
            r[3] = (v == 2) || (v == -2);
            r[2] = 1'b1;
            r[1] = (v == 0);
        end
        r[0] = done;
        return r;
    endfunction

    // Model update on each edge: reset, then start, then count down the remaining steps.
    always @(posedge clock) begin
        if (reset) begin
            left32 = 0; done32 = 0; left8 = 0; done8 = 0;
        end else if (start) begin
            left32 = 16; done32 = 0; left8 = 4; done8 = 0;
        end else begin
            if (left32 > 0) begin left32--; if (left32 == 0) done32 = 1; end
            if (left8 > 0)  begin left8--;  if (left8 == 0)  done8 = 1;  end
        end
    end

    // Every-cycle comparison of both instances against the model.
    always @(negedge clock) begin
        if (chk_en) begin
            chk("model32", o32, expect_out(left32, done32, data_in));
            chk("model8",  o8,  expect_out(left8,  done8,  data_in));
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
        data_in = 3'($urandom_range(0, 7));
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Count RUN cycles and the cycle index at which ready first appears, over a fixed window.
    task automatic run_count(input int ncyc, output int runs32, output int at32,
                             output int runs8, output int at8);
        runs32 = 0; at32 = 0; runs8 = 0; at8 = 0;
        for (int n = 1; n <= ncyc; n++) begin
            @(negedge clock);
            if (sp32) runs32++;
            if (sp8)  runs8++;
            if (rdy32 && at32 == 0) at32 = n;
            if (rdy8 && at8 == 0)   at8 = n;
            tick();
        end
    endtask

    logic [5:0] sweep_exp [8];
    int r32, a32, r8, a8, rdy_seen;

    initial begin
        sweep_exp[0] = 6'b000110; sweep_exp[1] = 6'b100100;
        sweep_exp[2] = 6'b100100; sweep_exp[3] = 6'b101100;
        sweep_exp[4] = 6'b011100; sweep_exp[5] = 6'b010100;
        sweep_exp[6] = 6'b010100; sweep_exp[7] = 6'b000110;

        // Reset held two cycles with start high: reset must dominate.
        tick();
        chk_en = 1'b1;
        tick();
        @(negedge clock);
        chk("reset_outs32", o32, 6'b0);
        chk("reset_outs8",  o8,  6'b0);
        reset = 1'b0;
        start = 1'b0;
        tick(); tick();
        @(negedge clock);
        chk("post_reset_idle", o32, 6'b0);

        // Decode sweep during RUN, pinned to literal expectations.
        pulse_start();
        for (int i = 0; i < 8; i++) begin
            data_in = 3'(i);
            @(negedge clock);
            chk($sformatf("sweep_%0d", i), o32, 32'(sweep_exp[i]));
            @(posedge clock);
            #1;
        end
        for (int i = 0; i < 12; i++) tick();

        // Full step count from a single start pulse, then DONE held.
        pulse_start();
        run_count(30, r32, a32, r8, a8);
        chk("runs32", r32, 16);
        chk("ready_at32", a32, 17);
        chk("runs8", r8, 4);
        chk("ready_at8", a8, 5);
        @(negedge clock);
        chk("done_hold32", o32, 6'b000001);

        // Start while in DONE, then restart mid-run at step 7.
        pulse_start();
        for (int i = 0; i < 6; i++) tick();
        @(negedge clock);
        chk("mid_run_not_ready", rdy32, 1'b0);
        tick();
        pulse_start();
        run_count(25, r32, a32, r8, a8);
        chk("restart_runs32", r32, 16);
        chk("restart_ready_at32", a32, 17);

        // Reset at step 5: outputs drop next cycle and ready stays low.
        pulse_start();
        for (int i = 0; i < 4; i++) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        @(negedge clock);
        chk("reset_mid_run", o32, 6'b0);
        rdy_seen = 0;
        for (int i = 0; i < 25; i++) begin
            @(negedge clock);
            if (rdy32 || sp32) rdy_seen++;
            tick();
        end
        chk("no_ready_after_reset", rdy_seen, 0);

        // WIDTH=8: reach DONE, then start from DONE -> ready drops and a new 4-step run follows.
        pulse_start();
        for (int i = 0; i < 6; i++) tick();
        @(negedge clock);
        chk("w8_done", o8, 6'b000001);
        pulse_start();
        run_count(10, r32, a32, r8, a8);
        chk("w8_rerun_runs", r8, 4);
        chk("w8_rerun_ready_at", a8, 5);

        // Random traffic: occasional starts (sometimes held), rare resets, random windows.
        for (int i = 0; i < 3000; i++) begin
            start = ($urandom_range(0, 11) == 0);
            reset = ($urandom_range(0, 59) == 0);
            tick();
        end
        start = 1'b0;
        reset = 1'b0;
        tick();
        @(negedge clock);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
